// File: rtl/vga_pkg.sv
// Shared VGA timing constants and line-buffer types.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int WORD_W   = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } lb_state_t;

  function automatic int words_per_line(input int h_active, input int word_w);
    return h_active / word_w;
  endfunction

endpackage

// File: rtl/vga_line_buffer_if.sv
// Producer-side write handshake of the line buffer.
interface vga_line_buffer_if
  import vga_pkg::*;
#(
  parameter int WORD_W = vga_pkg::WORD_W
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/vga_line_buffer_line_bank.sv
// One line of 1-bpp storage: word-addressed write port, bit-addressed async read port.
module line_bank
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int WORD_W   = vga_pkg::WORD_W,
  parameter int WA_W     = $clog2(H_ACTIVE / WORD_W),
  parameter int RA_W     = $clog2(H_ACTIVE)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WA_W-1:0]   waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr,
  output logic              rdata
);

  logic [H_ACTIVE-1:0] mem_q;
  logic [H_ACTIVE-1:0] mem_d;
  logic [RA_W-1:0]     wbase;

  always_comb begin
    wbase = RA_W'(waddr) * RA_W'(WORD_W);
    mem_d = mem_q;
    if (we) begin
      mem_d[wbase +: WORD_W] = wdata;
    end
  end

  // Pixel storage is not reset; fill status lives in the parent's counters.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vga_line_buffer.sv
// Ping-pong 1-bpp line buffer: producer fills one bank while the other is shifted out to img_reg.
//
// state  | meaning
// IDLE   | no line in progress; img_reg held at 0
// ACTIVE | serializing the display bank, rd_cnt < H_ACTIVE
module vga_line_buffer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int WORD_W   = vga_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  vga_line_buffer_if.slave  wr,
  input  logic              line_start,
  input  logic              pix_en,
  output logic              img_reg,
  output logic              underrun
);

  localparam int WORDS = words_per_line(H_ACTIVE, WORD_W);
  localparam int WC_W  = $clog2(WORDS + 1);
  localparam int WA_W  = $clog2(WORDS);
  localparam int RC_W  = $clog2(H_ACTIVE + 1);
  localparam int RA_W  = $clog2(H_ACTIVE);

  localparam logic [0:0] S_IDLE   = IDLE;
  localparam logic [0:0] S_ACTIVE = ACTIVE;

  logic [WC_W-1:0] wr_cnt_q,   wr_cnt_d;
  logic            wr_ready_q, wr_ready_d;
  logic            disp_sel_q, disp_sel_d;
  logic            blank_q,    blank_d;
  logic            underrun_q, underrun_d;
  logic [RC_W-1:0] rd_cnt_q,   rd_cnt_d;
  logic [0:0]      state_q,    state_d;
  logic            img_q,      img_d;

  logic            wr_fire;
  logic [WC_W-1:0] wc_plus;
  logic            full_now;
  logic            we0, we1;
  logic            rdata0, rdata1;
  logic            disp_pix;

  assign wr_fire  = wr.wr_valid && wr_ready_q;
  assign wc_plus  = wr_cnt_q + WC_W'(wr_fire);
  assign full_now = (wc_plus == WC_W'(WORDS));

  // Bank 0 is the fill bank while bank 1 is displayed, and vice versa.
  assign we0      = wr_fire &&  disp_sel_q;
  assign we1      = wr_fire && !disp_sel_q;
  assign disp_pix = disp_sel_q ? rdata1 : rdata0;

  line_bank #(
    .H_ACTIVE (H_ACTIVE),
    .WORD_W   (WORD_W),
    .WA_W     (WA_W),
    .RA_W     (RA_W)
  ) u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (wr_cnt_q[WA_W-1:0]),
    .wdata (wr.wr_data),
    .raddr (rd_cnt_q[RA_W-1:0]),
    .rdata (rdata0)
  );

  line_bank #(
    .H_ACTIVE (H_ACTIVE),
    .WORD_W   (WORD_W),
    .WA_W     (WA_W),
    .RA_W     (RA_W)
  ) u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (wr_cnt_q[WA_W-1:0]),
    .wdata (wr.wr_data),
    .raddr (rd_cnt_q[RA_W-1:0]),
    .rdata (rdata1)
  );

  // Write side and bank swap. A word landing on the line_start edge counts toward "full".
  always_comb begin
    wr_cnt_d   = wc_plus;
    wr_ready_d = (wc_plus != WC_W'(WORDS));
    disp_sel_d = disp_sel_q;
    blank_d    = blank_q;
    underrun_d = 1'b0;
    if (line_start) begin
      if (full_now) begin
        disp_sel_d = ~disp_sel_q;
        wr_cnt_d   = '0;
        wr_ready_d = 1'b1;
        blank_d    = 1'b0;
      end else begin
        blank_d    = 1'b1;
        underrun_d = 1'b1;
      end
    end
  end

  // Read side: line_start wins over a coincident pix_en.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    img_d    = 1'b0;
    if (line_start) begin
      state_d  = S_ACTIVE;
      rd_cnt_d = '0;
    end else if (state_q == S_ACTIVE && pix_en && rd_cnt_q < RC_W'(H_ACTIVE)) begin
      img_d    = ~blank_q & disp_pix;
      rd_cnt_d = rd_cnt_q + RC_W'(1);
      if (rd_cnt_d == RC_W'(H_ACTIVE)) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      wr_ready_q <= 1'b1;
      disp_sel_q <= 1'b0;
      blank_q    <= 1'b1;
      underrun_q <= 1'b0;
      rd_cnt_q   <= RC_W'(H_ACTIVE);
      state_q    <= S_IDLE;
      img_q      <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_ready_q <= wr_ready_d;
      disp_sel_q <= disp_sel_d;
      blank_q    <= blank_d;
      underrun_q <= underrun_d;
      rd_cnt_q   <= rd_cnt_d;
      state_q    <= state_d;
      img_q      <= img_d;
    end
  end

  assign wr.wr_ready = wr_ready_q;
  assign img_reg     = img_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Self-checking bench for vga_line_buffer: directed scenarios plus randomized traffic against a queue-based line model.
module tb_vga_line_buffer;

  logic clk;
  logic rst;
  logic line_start;
  logic pix_en;
  logic img_reg;
  logic underrun;

  int n_tests;
  int n_fail;

  vga_line_buffer_if #(.WORD_W(16)) wr_if ();

  vga_line_buffer #(.H_ACTIVE(640), .WORD_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if),
    .line_start (line_start),
    .pix_en     (pix_en),
    .img_reg    (img_reg),
    .underrun   (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a queue of accepted words and a snapshot of the line on show.
  logic [15:0]  m_fill[$];
  logic [639:0] m_disp;
  bit           m_blank;
  int           m_pix;
  bit           exp_img;
  bit           exp_ready;
  bit           exp_und;
  bit           m_fire;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fill.delete();
      m_blank   = 1'b1;
      m_pix     = 640;
      exp_img   = 1'b0;
      exp_ready = 1'b1;
      exp_und   = 1'b0;
    end else begin
      m_fire = wr_if.wr_valid && exp_ready;
      if (m_fire) m_fill.push_back(wr_if.wr_data);
      exp_und = 1'b0;
      exp_img = 1'b0;
      if (line_start) begin
        if (m_fill.size() == 40) begin
          for (int i = 0; i < 40; i++) m_disp[i*16 +: 16] = m_fill[i];
          m_fill.delete();
          m_blank = 1'b0;
        end else begin
          m_blank = 1'b1;
          exp_und = 1'b1;
        end
        m_pix = 0;
      end else if (pix_en && m_pix < 640) begin
        exp_img = m_blank ? 1'b0 : m_disp[m_pix];
        m_pix++;
      end
      exp_ready = (m_fill.size() != 40);
    end
  end

  task automatic cyc(input bit v, input logic [15:0] d, input bit ls, input bit pe);
    wr_if.wr_valid = v;
    wr_if.wr_data  = d;
    line_start     = ls;
    pix_en         = pe;
    @(negedge clk);
  endtask

  task automatic test_reset_state();
    n_tests++;
    if (img_reg !== 1'b0) begin n_fail++; $display("FAIL reset_img: got %0b want 0", img_reg); end
    n_tests++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", wr_if.wr_ready); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %0b want 0", underrun); end
  endtask

  task automatic test_full_line();
    logic [15:0] pat;
    pat = 16'hAAAA;
    for (int i = 0; i < 40; i++) cyc(1'b1, pat, 1'b0, 1'b0);
    n_tests++;
    if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_fall: got %0b want 0", wr_if.wr_ready); end
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise: got %0b want 1", wr_if.wr_ready); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL full_no_underrun: got %0b want 0", underrun); end
    for (int i = 0; i < 640; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      n_tests++;
      if (img_reg !== pat[i%16]) begin n_fail++; $display("FAIL full_pixel %0d: got %0b want %0b", i, img_reg, pat[i%16]); end
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (img_reg !== 1'b0) begin n_fail++; $display("FAIL full_after_line: got %0b want 0", img_reg); end
  endtask

  task automatic test_backpressure();
    logic [15:0] w [41];
    int idx;
    bit rdy;
    for (int i = 0; i < 41; i++) w[i] = 16'($urandom);
    idx = 0;
    for (int c = 0; c < 41; c++) begin
      rdy = (c < 40);
      n_tests++;
      if (wr_if.wr_ready !== rdy) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %0b want %0b", c, wr_if.wr_ready, rdy); end
      cyc(1'b1, w[idx], 1'b0, 1'b0);
      if (rdy) idx++;
    end
    n_tests++;
    if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_41st_offered: got %0b want 0", wr_if.wr_ready); end
    cyc(1'b1, w[40], 1'b1, 1'b0);
    n_tests++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_ls: got %0b want 1", wr_if.wr_ready); end
    for (int i = 0; i < 640; i++) begin
      cyc(i == 0, w[40], 1'b0, 1'b1);
      n_tests++;
      if (img_reg !== w[i/16][i%16]) begin n_fail++; $display("FAIL bp_pixel %0d: got %0b want %0b", i, img_reg, w[i/16][i%16]); end
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_underrun();
    // One word is already waiting from the backpressure scenario.
    for (int i = 0; i < 38; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_pulse: got %0b want 1", underrun); end
    for (int i = 0; i < 640; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      if (i == 0) begin
        n_tests++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_one_cycle: got %0b want 0", underrun); end
      end
      n_tests++;
      if (img_reg !== 1'b0) begin n_fail++; $display("FAIL ur_blank_pixel %0d: got %0b want 0", i, img_reg); end
    end
    n_tests++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL ur_ready_39: got %0b want 1", wr_if.wr_ready); end
    cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    n_tests++;
    if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL ur_40th_completes: got %0b want 0", wr_if.wr_ready); end
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_recover_no_pulse: got %0b want 0", underrun); end
    for (int i = 0; i < 640; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      n_tests++;
      if (img_reg !== exp_img) begin n_fail++; $display("FAIL ur_recover_pixel %0d: got %0b want %0b", i, img_reg, exp_img); end
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_edge_collision();
    logic [15:0] w [40];
    for (int i = 0; i < 40; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 39; i++) cyc(1'b1, w[i], 1'b0, 1'b0);
    cyc(1'b1, w[39], 1'b1, 1'b0);
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL edge_no_underrun: got %0b want 0", underrun); end
    n_tests++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL edge_ready: got %0b want 1", wr_if.wr_ready); end
    for (int i = 0; i < 640; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      n_tests++;
      if (img_reg !== w[i/16][i%16]) begin n_fail++; $display("FAIL edge_pixel %0d: got %0b want %0b", i, img_reg, w[i/16][i%16]); end
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_extra_pix_en();
    logic [15:0] w [40];
    for (int i = 0; i < 40; i++) w[i] = 16'($urandom) | 16'h0001;
    for (int i = 0; i < 40; i++) cyc(1'b1, w[i], 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 645; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      n_tests++;
      if (i < 640) begin
        if (img_reg !== w[i/16][i%16]) begin n_fail++; $display("FAIL extra_pixel %0d: got %0b want %0b", i, img_reg, w[i/16][i%16]); end
      end else begin
        if (img_reg !== 1'b0) begin n_fail++; $display("FAIL extra_no_wrap %0d: got %0b want 0", i, img_reg); end
      end
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int vprob;
    int npix;
    int gap;
    bit ls;
    bit pe;
    bit v;
    for (int ln = 0; ln < 6; ln++) begin
      vprob = (ln % 3 == 1) ? 5 : 75;
      npix  = (ln == 3) ? 300 : 640 + int'($urandom_range(0, 4));
      gap   = int'($urandom_range(0, 40));
      for (int c = 0; c < npix + 1 + gap; c++) begin
        ls = (c == 0);
        pe = (c == 0) ? bit'($urandom_range(0, 1)) : (c <= npix);
        v  = (int'($urandom_range(0, 99)) < vprob);
        cyc(v, 16'($urandom), ls, pe);
        n_tests++;
        if (img_reg !== exp_img) begin n_fail++; $display("FAIL rnd_img line %0d cyc %0d: got %0b want %0b", ln, c, img_reg, exp_img); end
        n_tests++;
        if (wr_if.wr_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready line %0d cyc %0d: got %0b want %0b", ln, c, wr_if.wr_ready, exp_ready); end
        n_tests++;
        if (underrun !== exp_und) begin n_fail++; $display("FAIL rnd_underrun line %0d cyc %0d: got %0b want %0b", ln, c, underrun, exp_und); end
      end
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 100; k++) begin
      if (!exp_ready) break;
      cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
    end
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) cyc(1'b1, 16'hFFFF, 1'b0, 1'b1);
    n_tests++;
    if (img_reg !== 1'b1) begin n_fail++; $display("FAIL rst_pre_img: got %0b want 1", img_reg); end
    n_tests++;
    if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_ready: got %0b want 0", wr_if.wr_ready); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (img_reg !== 1'b0) begin n_fail++; $display("FAIL rst_img: got %0b want 0", img_reg); end
    n_tests++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", wr_if.wr_ready); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %0b want 0", underrun); end
    wr_if.wr_valid = 1'b0;
    pix_en         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL rst_first_ls_underrun: got %0b want 1", underrun); end
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun_clears: got %0b want 0", underrun); end
    n_tests++;
    if (img_reg !== 1'b0) begin n_fail++; $display("FAIL rst_blank_line: got %0b want 0", img_reg); end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 16'h0;
    line_start     = 1'b0;
    pix_en         = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset_state();
    test_full_line();
    test_backpressure();
    test_underrun();
    test_edge_collision();
    test_extra_pix_en();
    test_random();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
